// File: rtl/execute_stage.sv
// ============================================================================
//  Module      : execute_stage
//  Description : 16-bit execute stage. Single-cycle ALU ops (ADD, SUB, AND,
//                LDR, STR, MOVI) with two-level operand forwarding and a
//                load-use hazard stall; MUL (and optionally DIV) run on an
//                iterative 16-step shift-add / restoring-subtract engine
//                sequenced by an IDLE/BUSY/FINISH state machine.
//  Config      : define TSP16_HW_DIV_EN to build the hardware divider.
//                Without it opcode 1000 executes as a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        decode_valid,
    input  logic [15:0] decode_instr,
    output logic [2:0]  execute_rn_num,
    output logic [2:0]  execute_rm_num,
    input  logic [15:0] execute_rn_val,
    input  logic [15:0] execute_rm_val,
    input  logic        memory_is_dependent,
    input  logic [15:0] memory_result,
    input  logic [15:0] memory_instr,
    output logic        execute_stall,
    output logic        execute_done,
    output logic        execute_is_dependent,
    output logic [15:0] execute_result,
    output logic [15:0] execute_instr
);

    // ------------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_OP_NOP  = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_SUB  = 4'b0010;
    localparam logic [3:0] c_OP_AND  = 4'b0011;
    localparam logic [3:0] c_OP_LDR  = 4'b0100;
    localparam logic [3:0] c_OP_STR  = 4'b0101;
    localparam logic [3:0] c_OP_MOVI = 4'b0110;
    localparam logic [3:0] c_OP_MUL  = 4'b0111;
`ifdef TSP16_HW_DIV_EN
    localparam logic [3:0] c_OP_DIV  = 4'b1000;
`endif

    localparam logic [4:0] c_LAST_STEP = 5'd15;

    typedef enum logic [1:0] {
        c_ST_IDLE   = 2'd0,
        c_ST_BUSY   = 2'd1,
        c_ST_FINISH = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_done;
    logic        r_dep;
    logic [15:0] r_result;
    logic [15:0] r_instr;

    logic [4:0]  r_count;
    logic [15:0] r_op_a;        // multiplicand (MUL) / dividend-then-quotient (DIV)
    logic [15:0] r_op_b;        // multiplier (MUL) / divisor (DIV)
    logic [15:0] r_acc;         // product (MUL) / partial remainder (DIV)
    logic [15:0] r_pend_instr;  // instruction being computed iteratively

    logic [3:0]  w_op;
    logic [2:0]  w_rn_idx;
    logic [2:0]  w_rm_idx;
    logic [15:0] w_opnd_a;
    logic [15:0] w_opnd_b;
    logic        w_load_use;
    logic        w_is_multi;
    logic        w_accept;
    logic        w_fsm_stall;
    logic [15:0] w_sc_result;
    logic        w_sc_dep;
    logic [15:0] w_mul_acc;
    logic        w_step_div;
    logic        w_div_ge;
    logic [15:0] w_div_rem;
    logic [15:0] w_fin_result;
    logic        w_unused;

    // ------------------------------------------------------------------------
    // Decode fields and register-file read indices
    // ------------------------------------------------------------------------
    assign w_op           = decode_instr[15:12];
    assign w_rn_idx       = decode_instr[5:3];
    assign w_rm_idx       = decode_instr[8:6];
    assign execute_rn_num = w_rn_idx;
    assign execute_rm_num = w_rm_idx;

    // Only the destination field of the memory-stage instruction matters here.
    assign w_unused = &{1'b0, memory_instr[15:3]};

    // Operand forwarding: execute-stage result beats memory-stage result beats regfile.
    always_comb begin
        w_opnd_a = execute_rn_val;
        w_opnd_b = execute_rm_val;
        if (r_dep && (r_instr[2:0] == w_rn_idx)) begin
            w_opnd_a = r_result;
        end else if (memory_is_dependent && (memory_instr[2:0] == w_rn_idx)) begin
            w_opnd_a = memory_result;
        end
        if (r_dep && (r_instr[2:0] == w_rm_idx)) begin
            w_opnd_b = r_result;
        end else if (memory_is_dependent && (memory_instr[2:0] == w_rm_idx)) begin
            w_opnd_b = memory_result;
        end
    end

    // A load still in execute cannot forward its data yet; the consumer waits a cycle.
    assign w_load_use = decode_valid && r_dep && (r_instr[15:12] == c_OP_LDR) &&
                        ((r_instr[2:0] == w_rn_idx) || (r_instr[2:0] == w_rm_idx));

`ifdef TSP16_HW_DIV_EN
    assign w_is_multi = (w_op == c_OP_MUL) || (w_op == c_OP_DIV);
`else
    assign w_is_multi = (w_op == c_OP_MUL);
`endif

    // Single-cycle result and destination-write flag for the decoded opcode.
    always_comb begin
        w_sc_result = 16'h0000;
        w_sc_dep    = 1'b0;
        case (w_op)
            c_OP_NOP: begin
                w_sc_result = 16'h0000;
                w_sc_dep    = 1'b0;
            end
            c_OP_ADD: begin
                w_sc_result = w_opnd_a + w_opnd_b;
                w_sc_dep    = 1'b1;
            end
            c_OP_SUB: begin
                w_sc_result = w_opnd_a - w_opnd_b;
                w_sc_dep    = 1'b1;
            end
            c_OP_AND: begin
                w_sc_result = w_opnd_a & w_opnd_b;
                w_sc_dep    = 1'b1;
            end
            c_OP_LDR: begin
                w_sc_result = w_opnd_a;
                w_sc_dep    = 1'b1;
            end
            c_OP_STR: begin
                w_sc_result = w_opnd_a;
                w_sc_dep    = 1'b0;
            end
            c_OP_MOVI: begin
                w_sc_result = {8'h00, decode_instr[10:3]};
                w_sc_dep    = 1'b1;
            end
            default: begin
                w_sc_result = 16'h0000;
                w_sc_dep    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Iterative engine step logic
    // ------------------------------------------------------------------------
    assign w_mul_acc = r_acc + (r_op_b[0] ? r_op_a : 16'h0000);

`ifdef TSP16_HW_DIV_EN
    logic [16:0] w_div_shift;
    logic [15:0] w_div_diff;

    // Restoring division: shift next dividend bit into the remainder, subtract if it fits.
    // A zero divisor always "fits", which naturally yields an all-ones quotient.
    assign w_div_shift  = {r_acc, r_op_a[15]};
    assign w_div_diff   = w_div_shift[15:0] - r_op_b;
    assign w_div_ge     = (w_div_shift >= {1'b0, r_op_b});
    assign w_div_rem    = w_div_ge ? w_div_diff : w_div_shift[15:0];
    assign w_step_div   = (r_pend_instr[15:12] == c_OP_DIV);
`else
    assign w_div_ge     = 1'b0;
    assign w_div_rem    = 16'h0000;
    assign w_step_div   = 1'b0;
`endif

    assign w_fin_result = w_step_div ? r_op_a : r_acc;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, acceptance and multi-cycle stall.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fsm_stall = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (decode_valid && !w_load_use) begin
                    w_accept = 1'b1;
                    if (w_is_multi) begin
                        w_state_nxt = c_ST_BUSY;
                    end
                end
            end
            c_ST_BUSY: begin
                w_fsm_stall = 1'b1;
                if (r_count == c_LAST_STEP) begin
                    w_state_nxt = c_ST_FINISH;
                end
            end
            c_ST_FINISH: begin
                w_fsm_stall = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // The FSM stall dominates; a load-use stall is only possible while idle.
    assign execute_stall = w_fsm_stall || ((r_state == c_ST_IDLE) && w_load_use);

    // Operand latch on acceptance, then one shift-add / restoring step per BUSY cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= 5'd0;
            r_op_a       <= 16'h0000;
            r_op_b       <= 16'h0000;
            r_acc        <= 16'h0000;
            r_pend_instr <= 16'h0000;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept && w_is_multi) begin
                        r_count      <= 5'd0;
                        r_op_a       <= w_opnd_a;
                        r_op_b       <= w_opnd_b;
                        r_acc        <= 16'h0000;
                        r_pend_instr <= decode_instr;
                    end
                end
                c_ST_BUSY: begin
                    r_count <= (r_count == c_LAST_STEP) ? 5'd0 : r_count + 5'd1;
                    if (w_step_div) begin
                        r_acc  <= w_div_rem;
                        r_op_a <= {r_op_a[14:0], w_div_ge};
                    end else begin
                        r_acc  <= w_mul_acc;
                        r_op_a <= {r_op_a[14:0], 1'b0};
                        r_op_b <= {1'b0, r_op_b[15:1]};
                    end
                end
                default: begin
                    r_count <= 5'd0;
                end
            endcase
        end
    end

    // Pipeline output register: bubble by default, result on single-cycle accept or FINISH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done   <= 1'b0;
            r_dep    <= 1'b0;
            r_result <= 16'h0000;
            r_instr  <= 16'h0000;
        end else begin
            r_done   <= 1'b0;
            r_dep    <= 1'b0;
            r_result <= 16'h0000;
            r_instr  <= 16'h0000;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept && !w_is_multi) begin
                        r_done   <= 1'b1;
                        r_dep    <= w_sc_dep;
                        r_result <= w_sc_result;
                        r_instr  <= decode_instr;
                    end
                end
                c_ST_FINISH: begin
                    r_done   <= 1'b1;
                    r_dep    <= 1'b1;
                    r_result <= w_fin_result;
                    r_instr  <= r_pend_instr;
                end
                default: begin
                end
            endcase
        end
    end

    assign execute_done         = r_done;
    assign execute_is_dependent = r_dep;
    assign execute_result       = r_result;
    assign execute_instr        = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Self-checking bench for execute_stage. A cycle-level
//                reference model (arithmetic on whole values, a countdown
//                for multi-cycle ops) predicts stall and pipeline outputs;
//                the memory stage is emulated by delaying the model's own
//                predicted execute outputs by one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_execute_stage;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_LDR  = 4'd4;
    localparam logic [3:0] OP_STR  = 4'd5;
    localparam logic [3:0] OP_MOVI = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_DIV  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        decode_valid;
    logic [15:0] decode_instr;
    logic [2:0]  execute_rn_num;
    logic [2:0]  execute_rm_num;
    logic [15:0] execute_rn_val;
    logic [15:0] execute_rm_val;
    logic        memory_is_dependent;
    logic [15:0] memory_result;
    logic [15:0] memory_instr;
    logic        execute_stall;
    logic        execute_done;
    logic        execute_is_dependent;
    logic [15:0] execute_result;
    logic [15:0] execute_instr;

    logic [15:0] regs [8];
    assign execute_rn_val = regs[execute_rn_num];
    assign execute_rm_val = regs[execute_rm_num];

    always #5 clk = ~clk;

    execute_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .decode_valid         (decode_valid),
        .decode_instr         (decode_instr),
        .execute_rn_num       (execute_rn_num),
        .execute_rm_num       (execute_rm_num),
        .execute_rn_val       (execute_rn_val),
        .execute_rm_val       (execute_rm_val),
        .memory_is_dependent  (memory_is_dependent),
        .memory_result        (memory_result),
        .memory_instr         (memory_instr),
        .execute_stall        (execute_stall),
        .execute_done         (execute_done),
        .execute_is_dependent (execute_is_dependent),
        .execute_result       (execute_result),
        .execute_instr        (execute_instr)
    );

    int          compared   = 0;
    int          mismatched = 0;
    bit          rand_mode  = 1'b0;
    logic [15:0] ld_data    = 16'h0000;

    // Reference model state: predicted execute outputs and multi-cycle countdown.
    logic        m_done  = 1'b0;
    logic        m_dep   = 1'b0;
    logic [15:0] m_res   = 16'h0000;
    logic [15:0] m_instr = 16'h0000;
    int          busy_left = 0;
    logic [15:0] pend_res   = 16'h0000;
    logic [15:0] pend_instr = 16'h0000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk_r(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rn, input logic [2:0] rm);
        return {op, 3'b000, rm, rn, rd};
    endfunction

    function automatic logic [15:0] mk_i(input logic [2:0] rd, input logic [7:0] imm);
        return {OP_MOVI, 1'b0, imm, rd};
    endfunction

    function automatic logic [15:0] fwd(input logic [2:0] idx);
        if (m_dep && (m_instr[2:0] == idx)) return m_res;
        if (memory_is_dependent && (memory_instr[2:0] == idx)) return memory_result;
        return regs[idx];
    endfunction

    function automatic bit div_enabled();
`ifdef TSP16_HW_DIV_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle. Entered at posedge+1 with decode inputs already driven.
    task automatic cycle(output bit accepted);
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        e_stall;
        logic        n_done, n_dep;
        logic [15:0] n_res, n_instr;
        bit          lu;
        accepted = 1'b0;
        #1;
        op = decode_instr[15:12];
        lu = decode_valid && m_dep && (m_instr[15:12] == OP_LDR) &&
             ((m_instr[2:0] == decode_instr[5:3]) || (m_instr[2:0] == decode_instr[8:6]));
        n_done = 1'b0; n_dep = 1'b0; n_res = 16'h0; n_instr = 16'h0;
        e_stall = 1'b0;
        if (busy_left > 0) begin
            e_stall = 1'b1;
            busy_left--;
            if (busy_left == 0) begin
                n_done = 1'b1; n_dep = 1'b1; n_res = pend_res; n_instr = pend_instr;
            end
        end else if (lu) begin
            e_stall = 1'b1;
        end else if (decode_valid) begin
            accepted = 1'b1;
            a = fwd(decode_instr[5:3]);
            b = fwd(decode_instr[8:6]);
            if (op == OP_MUL || (op == OP_DIV && div_enabled())) begin
                busy_left  = 17;
                pend_instr = decode_instr;
                if (op == OP_MUL) pend_res = 16'(32'(a) * 32'(b));
                else              pend_res = (b == 16'h0) ? 16'hFFFF : a / b;
            end else begin
                n_done  = 1'b1;
                n_instr = decode_instr;
                case (op)
                    OP_ADD:  begin n_res = a + b; n_dep = 1'b1; end
                    OP_SUB:  begin n_res = a - b; n_dep = 1'b1; end
                    OP_AND:  begin n_res = a & b; n_dep = 1'b1; end
                    OP_LDR:  begin n_res = a;     n_dep = 1'b1; end
                    OP_STR:  begin n_res = a;     n_dep = 1'b0; end
                    OP_MOVI: begin n_res = {8'h00, decode_instr[10:3]}; n_dep = 1'b1; end
                    default: begin n_res = 16'h0; n_dep = 1'b0; end
                endcase
            end
        end
        chk("stall", 16'(execute_stall), 16'(e_stall));
        chk("rn_num", 16'(execute_rn_num), 16'(decode_instr[5:3]));
        chk("rm_num", 16'(execute_rm_num), 16'(decode_instr[8:6]));
        @(posedge clk);
        #1;
        // Memory stage receives what execute held; a load brings back its data.
        memory_is_dependent = m_dep;
        memory_instr        = m_instr;
        memory_result       = (m_dep && m_instr[15:12] == OP_LDR) ? ld_data : m_res;
        m_done = n_done; m_dep = n_dep; m_res = n_res; m_instr = n_instr;
        chk("done", 16'(execute_done), 16'(m_done));
        chk("dep", 16'(execute_is_dependent), 16'(m_dep));
        chk("result", execute_result, m_res);
        chk("instr", execute_instr, m_instr);
        if (rand_mode) begin
            for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
            ld_data = 16'($urandom);
        end
    endtask

    task automatic issue(input logic [15:0] ins, output int ncyc);
        bit acc;
        ncyc = 0;
        acc  = 1'b0;
        decode_valid = 1'b1;
        decode_instr = ins;
        while (!acc && ncyc < 40) begin
            cycle(acc);
            ncyc++;
        end
        compared++;
        assert (acc) else begin
            mismatched++;
            $error("FAIL accept_timeout: observed=%0d cycles expected=acceptance", ncyc);
        end
        decode_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        decode_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [15:0] ins;
        reset               = 1'b0;
        decode_valid        = 1'b0;
        decode_instr        = 16'h0000;
        memory_is_dependent = 1'b0;
        memory_result       = 16'h0000;
        memory_instr        = 16'h0000;
        for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h0101);

        // Reset state
        #3;
        chk("rst_stall", 16'(execute_stall), 16'h0);
        chk("rst_done", 16'(execute_done), 16'h0);
        chk("rst_dep", 16'(execute_is_dependent), 16'h0);
        chk("rst_result", execute_result, 16'h0);
        chk("rst_instr", execute_instr, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);

        // Back-to-back forwarding from both stages, no stall
        issue(mk_i(3'd1, 8'd5), n);
        issue(mk_i(3'd2, 8'd7), n);
        issue(mk_r(OP_ADD, 3'd3, 3'd1, 3'd2), n);
        chk("fwd_add_cycles", 16'(n), 16'd1);
        chk("fwd_add_result", execute_result, 16'd12);

        // Load-use hazard: one stall, one bubble, then forward the loaded data
        idle(2);
        ld_data = 16'h0010;
        issue(mk_r(OP_LDR, 3'd1, 3'd0, 3'd0), n);
        issue(mk_r(OP_ADD, 3'd2, 3'd1, 3'd1), n);
        chk("lu_cycles", 16'(n), 16'd2);
        chk("lu_add_result", execute_result, 16'h0020);

        // MUL overflow keeps the low half; the next instruction waits 17 stall cycles
        regs[1] = 16'h0100; regs[2] = 16'h0300;
        idle(2);
        issue(mk_r(OP_MUL, 3'd3, 3'd1, 3'd2), n);
        issue(mk_r(OP_ADD, 3'd4, 3'd3, 3'd1), n);
        chk("mul_next_cycles", 16'(n), 16'd18);
        chk("mul_add_result", execute_result, 16'h0100);

`ifdef TSP16_HW_DIV_EN
        regs[0] = 16'h0000; regs[1] = 16'd100; regs[2] = 16'd7;
        idle(2);
        issue(mk_r(OP_DIV, 3'd3, 3'd1, 3'd2), n);
        issue(mk_r(OP_ADD, 3'd4, 3'd3, 3'd0), n);
        chk("div_next_cycles", 16'(n), 16'd18);
        chk("div_100_7", execute_result, 16'd14);
        regs[1] = 16'h1234; regs[2] = 16'h0000;
        idle(2);
        issue(mk_r(OP_DIV, 3'd3, 3'd1, 3'd2), n);
        issue(mk_r(OP_ADD, 3'd4, 3'd3, 3'd0), n);
        chk("div_by_zero", execute_result, 16'hFFFF);
`else
        idle(2);
        issue(mk_r(OP_DIV, 3'd3, 3'd1, 3'd2), n);
        chk("div_off_cycles", 16'(n), 16'd1);
        chk("div_off_done", 16'(execute_done), 16'd1);
        chk("div_off_dep", 16'(execute_is_dependent), 16'd0);
        chk("div_off_result", execute_result, 16'h0000);
`endif

        // Reset in the 8th BUSY cycle abandons the multiply
        idle(2);
        issue(mk_r(OP_MUL, 3'd3, 3'd1, 3'd2), n);
        idle(7);
        reset = 1'b0;
        #1;
        chk("busy_rst_stall", 16'(execute_stall), 16'h0);
        chk("busy_rst_done", 16'(execute_done), 16'h0);
        chk("busy_rst_result", execute_result, 16'h0);
        chk("busy_rst_instr", execute_instr, 16'h0);
        busy_left = 0;
        m_done = 1'b0; m_dep = 1'b0; m_res = 16'h0; m_instr = 16'h0;
        memory_is_dependent = 1'b0; memory_result = 16'h0; memory_instr = 16'h0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(20);
        issue(mk_i(3'd4, 8'd9), n);
        chk("post_rst_cycles", 16'(n), 16'd1);
        chk("post_rst_movi", execute_result, 16'd9);

        // Randomized traffic against the model; register fields kept in r0..r3
        rand_mode = 1'b1;
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                ins = 16'($urandom) & 16'h0EDB;
                ins[15:12] = 4'($urandom_range(0, 15));
                issue(ins, n);
            end
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
